// File: rtl/pico_io_pkg.sv
// pico_io_pkg: shared constants for the PicoBlaze port-mapped FIFO slice.
//   OFS_*    : low port-ID offsets inside the 4-ID window
//   ST_*     : bit positions in the status byte
//   ENTRY_W  : FIFO entry width, {tag[1:0], data[7:0]}
package pico_io_pkg;

    localparam logic [1:0] OFS_STATUS = 2'd0;
    localparam logic [1:0] OFS_COUNT  = 2'd1;
    localparam logic [1:0] OFS_TAG    = 2'd2;
    localparam logic [1:0] OFS_DATA   = 2'd3;

    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_OVF   = 2;

    localparam int unsigned ENTRY_W = 10;

endpackage

// File: rtl/pico_sync_fifo.sv
// pico_sync_fifo: single-clock show-ahead FIFO.
//   clk, rst_n        : clock, synchronous active-low reset
//   push, wr_data     : store wr_data (accepted when not full, or when popping)
//   pop               : advance head (ignored when empty)
//   rd_data           : head entry, combinational from storage at read pointer
//   full, empty, count: occupancy state as of the last edge
module pico_sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [AW:0]      wr_ptr_q, rd_ptr_q, count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign count = count_q;

    assign pop_ok  = pop && !empty;
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (push_ok && !pop_ok) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/pico_port_fifo.sv
// pico_port_fifo: port-mapped write FIFO with status/read mux for PicoBlaze.
//   clk, cpu_reset            : clock, synchronous active-low reset
//   write_strobe, read_strobe : PicoBlaze I/O strobes
//   port_id, out_port         : PicoBlaze port address and write data
//   ext_in                    : read data for IDs outside the window
//   in_port                   : registered read data back to PicoBlaze
//   interrupt, interrupt_ack  : drain-complete request and its acknowledge
//   m_valid, m_ready          : head handshake to the consumer
//   m_tag, m_data             : head entry {port_id[1:0], data}
module pico_port_fifo
    import pico_io_pkg::*;
#(
    parameter logic [7:0]  BASE_ID = 8'h10,
    parameter int unsigned DEPTH   = 16
) (
    input  logic       clk,
    input  logic       cpu_reset,
    input  logic       write_strobe,
    input  logic       read_strobe,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic [7:0] ext_in,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [1:0] m_tag,
    output logic [7:0] m_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic               hit, wr_hit, push, pop, full, empty;
    logic               ovf_set, ovf_clr, int_event;
    logic [AW:0]        count;
    logic [ENTRY_W-1:0] head;
    logic [7:0]         status, rd_mux;
    logic               ovf_q, ovf_d, irq_q, irq_d;
    logic [7:0]         in_port_q;

    assign hit     = (port_id[7:2] == BASE_ID[7:2]);
    assign wr_hit  = write_strobe && hit;
    assign m_valid = !empty;
    assign pop     = m_valid && m_ready;
    assign push    = wr_hit && (!full || pop);
    assign ovf_set = wr_hit && full && !pop;
    assign ovf_clr = read_strobe && (port_id == BASE_ID);
    // Last entry leaves and nothing replaces it.
    assign int_event = pop && (count == (AW+1)'(1)) && !push;

    pico_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (cpu_reset),
        .push    (push),
        .pop     (pop),
        .wr_data ({port_id[1:0], out_port}),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign m_tag  = head[9:8];
    assign m_data = head[7:0];

    always_comb begin
        status           = '0;
        status[ST_EMPTY] = empty;
        status[ST_FULL]  = full;
        status[ST_OVF]   = ovf_q;
    end

    always_comb begin
        rd_mux = ext_in;
        if (hit) begin
            unique case (port_id[1:0])
                OFS_STATUS: rd_mux = status;
                OFS_COUNT:  rd_mux = 8'(count);
                OFS_TAG:    rd_mux = {6'b0, head[9:8]};
                OFS_DATA:   rd_mux = head[7:0];
                default:    rd_mux = ext_in;
            endcase
        end
    end

    // Set wins over clear for both sticky flags.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        irq_d = irq_q;
        if (int_event) begin
            irq_d = 1'b1;
        end else if (interrupt_ack) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!cpu_reset) begin
            ovf_q     <= 1'b0;
            irq_q     <= 1'b0;
            in_port_q <= 8'h00;
        end else begin
            ovf_q     <= ovf_d;
            irq_q     <= irq_d;
            in_port_q <= rd_mux;
        end
    end

    assign in_port   = in_port_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_pico_port_fifo.sv
module tb_pico_port_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       cpu_reset;
    logic       write_strobe, read_strobe;
    logic [7:0] port_id, out_port, ext_in;
    logic [7:0] in_port;
    logic       interrupt, interrupt_ack;
    logic       m_valid, m_ready;
    logic [1:0] m_tag;
    logic [7:0] m_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] exp_q[$];
    int         model_count;

    always #5 clk = ~clk;

    pico_port_fifo #(
        .BASE_ID (8'h10),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .cpu_reset     (cpu_reset),
        .write_strobe  (write_strobe),
        .read_strobe   (read_strobe),
        .port_id       (port_id),
        .out_port      (out_port),
        .ext_in        (ext_in),
        .in_port       (in_port),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_tag         (m_tag),
        .m_data        (m_data)
    );

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single hit write with m_ready low; the model records accepted entries.
    task automatic do_write(input logic [7:0] pid, input logic [7:0] data);
        write_strobe = 1'b1;
        port_id      = pid;
        out_port     = data;
        if (model_count < DEPTH) begin
            exp_q.push_back({pid[1:0], data});
            model_count++;
        end
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic test_reset();
        cpu_reset = 1'b0;
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0; m_ready = 1'b0;
        port_id = 8'h10; out_port = 8'h00; ext_in = 8'h00;
        tick();
        cpu_reset = 1'b1;
        exp_q.delete();
        model_count = 0;
        n_cmp++;
        if (in_port !== 8'h00) begin
            n_err++; $display("FAIL reset_in_port got %h want %h", in_port, 8'h00);
        end
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_m_valid got %b want 0", m_valid);
        end
        n_cmp++;
        if (interrupt !== 1'b0) begin
            n_err++; $display("FAIL reset_interrupt got %b want 0", interrupt);
        end
        tick();
        n_cmp++;
        if (in_port !== 8'h01) begin
            n_err++; $display("FAIL idle_status got %h want %h", in_port, 8'h01);
        end
    endtask

    task automatic test_passthrough();
        port_id = 8'h40; ext_in = 8'hF3;
        tick();
        n_cmp++;
        if (in_port !== 8'hF3) begin
            n_err++; $display("FAIL ext_passthrough got %h want %h", in_port, 8'hF3);
        end
        port_id = 8'h0F; ext_in = 8'h5A;
        tick();
        n_cmp++;
        if (in_port !== 8'h5A) begin
            n_err++; $display("FAIL ext_below_window got %h want %h", in_port, 8'h5A);
        end
    endtask

    task automatic test_single_write();
        do_write(8'h12, 8'hF3);
        n_cmp++;
        if (m_valid !== 1'b1) begin
            n_err++; $display("FAIL single_m_valid got %b want 1", m_valid);
        end
        n_cmp++;
        if ({m_tag, m_data} !== exp_q[0]) begin
            n_err++; $display("FAIL single_head got %h want %h", {m_tag, m_data}, exp_q[0]);
        end
        port_id = 8'h11;
        tick();
        n_cmp++;
        if (in_port !== 8'h01) begin
            n_err++; $display("FAIL single_count got %h want %h", in_port, 8'h01);
        end
        port_id = 8'h12;
        tick();
        n_cmp++;
        if (in_port !== {6'b0, exp_q[0][9:8]}) begin
            n_err++; $display("FAIL single_tag_read got %h want %h", in_port, {6'b0, exp_q[0][9:8]});
        end
        port_id = 8'h13;
        tick();
        n_cmp++;
        if (in_port !== exp_q[0][7:0]) begin
            n_err++; $display("FAIL single_data_read got %h want %h", in_port, exp_q[0][7:0]);
        end
        // Drain the single entry: a pop at count 1 raises the interrupt.
        m_ready = 1'b1;
        n_cmp++;
        if (exp_q.size() == 0 || {m_tag, m_data} !== exp_q[0]) begin
            n_err++; $display("FAIL single_pop got %h want entry", {m_tag, m_data});
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        model_count = 0;
        tick();
        m_ready = 1'b0;
        n_cmp++;
        if (interrupt !== 1'b1 || m_valid !== 1'b0) begin
            n_err++; $display("FAIL single_irq got irq=%b valid=%b want irq=1 valid=0",
                              interrupt, m_valid);
        end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        n_cmp++;
        if (interrupt !== 1'b0) begin
            n_err++; $display("FAIL single_ack got %b want 0", interrupt);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= 16; i++) do_write(8'h10, 8'(i));
        port_id = 8'h10;
        tick();
        n_cmp++;
        if (in_port !== 8'h06) begin
            n_err++; $display("FAIL ovf_status got %h want %h", in_port, 8'h06);
        end
        port_id = 8'h11;
        tick();
        n_cmp++;
        if (in_port !== 8'h10) begin
            n_err++; $display("FAIL ovf_count got %h want %h", in_port, 8'h10);
        end
        port_id = 8'h10; read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        n_cmp++;
        if (in_port !== 8'h06) begin
            n_err++; $display("FAIL ovf_clear_read got %h want %h", in_port, 8'h06);
        end
        tick();
        n_cmp++;
        if (in_port !== 8'h02) begin
            n_err++; $display("FAIL ovf_after_clear got %h want %h", in_port, 8'h02);
        end
    endtask

    task automatic test_drain_interrupt();
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (m_valid !== 1'b1 || interrupt !== 1'b0 || exp_q.size() == 0 ||
                {m_tag, m_data} !== exp_q[0]) begin
                n_err++;
                $display("FAIL drain_%0d got valid=%b irq=%b head=%h want valid=1 irq=0 head=%h",
                         i, m_valid, interrupt, {m_tag, m_data},
                         (exp_q.size() != 0) ? exp_q[0] : 10'h0);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            tick();
        end
        model_count = 0;
        m_ready = 1'b0;
        n_cmp++;
        if (interrupt !== 1'b1 || m_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_irq got irq=%b valid=%b want irq=1 valid=0",
                              interrupt, m_valid);
        end
        tick();
        tick();
        n_cmp++;
        if (interrupt !== 1'b1) begin
            n_err++; $display("FAIL drain_irq_hold got %b want 1", interrupt);
        end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        n_cmp++;
        if (interrupt !== 1'b0) begin
            n_err++; $display("FAIL drain_ack got %b want 0", interrupt);
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) do_write(8'h10 + 8'(i % 4), 8'h20 + 8'(i));
        // Push to a full FIFO while the head leaves.
        write_strobe = 1'b1; port_id = 8'h13; out_port = 8'hAA; m_ready = 1'b1;
        n_cmp++;
        if (exp_q.size() == 0 || {m_tag, m_data} !== exp_q[0]) begin
            n_err++; $display("FAIL pp_head got %h want entry", {m_tag, m_data});
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_q.push_back({2'd3, 8'hAA});
        tick();
        write_strobe = 1'b0; m_ready = 1'b0; port_id = 8'h11;
        tick();
        n_cmp++;
        if (in_port !== 8'h10) begin
            n_err++; $display("FAIL pp_count got %h want %h", in_port, 8'h10);
        end
        port_id = 8'h10;
        tick();
        n_cmp++;
        if (in_port !== 8'h02) begin
            n_err++; $display("FAIL pp_status got %h want %h", in_port, 8'h02);
        end
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_cmp++;
            if (m_valid !== 1'b1 || exp_q.size() == 0 || {m_tag, m_data} !== exp_q[0]) begin
                n_err++;
                $display("FAIL pp_drain_%0d got valid=%b head=%h want valid=1 head=%h",
                         i, m_valid, {m_tag, m_data}, (exp_q.size() != 0) ? exp_q[0] : 10'h0);
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            tick();
        end
        model_count = 0;
        m_ready = 1'b0;
        n_cmp++;
        if (m_valid !== 1'b0 || interrupt !== 1'b1) begin
            n_err++; $display("FAIL pp_end got valid=%b irq=%b want valid=0 irq=1",
                              m_valid, interrupt);
        end
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Leave interrupt pending, then load five entries.
        do_write(8'h10, 8'h77);
        m_ready = 1'b1;
        void'(exp_q.pop_front());
        model_count = 0;
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) do_write(8'h11, 8'h30 + 8'(i));
        n_cmp++;
        if (interrupt !== 1'b1 || m_valid !== 1'b1) begin
            n_err++; $display("FAIL mid_pre got irq=%b valid=%b want irq=1 valid=1",
                              interrupt, m_valid);
        end
        port_id = 8'h10; m_ready = 1'b1; cpu_reset = 1'b0;
        tick();
        cpu_reset = 1'b1;
        exp_q.delete();
        model_count = 0;
        n_cmp++;
        if (m_valid !== 1'b0 || interrupt !== 1'b0 || in_port !== 8'h00) begin
            n_err++; $display("FAIL mid_reset got valid=%b irq=%b in=%h want 0 0 00",
                              m_valid, interrupt, in_port);
        end
        tick();
        n_cmp++;
        if (in_port !== 8'h01 || interrupt !== 1'b0) begin
            n_err++; $display("FAIL mid_status got in=%h irq=%b want 01 0", in_port, interrupt);
        end
        m_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_single_write();
        test_overflow();
        test_drain_interrupt();
        test_full_push_pop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pico_port_fifo.md
# pico_port_fifo

Port-mapped write FIFO and status/read mux that sits directly downstream of `pico_top`. It captures PicoBlaze `OUTPUT` writes to a 4-ID window, tagged with the low port-ID bits, into a FIFO drained by a valid/ready consumer. It serves status and level reads back onto `in_port` and raises an interrupt when the FIFO drains.

## Interface
- `BASE_ID`, 8'h10: first port ID of the 4-ID window, aligned to 4.
- `DEPTH`, 16: FIFO entries, power of 2, ≥4. `AW = $clog2(DEPTH)`.
- `clk`  in  1  system clock, rising edge.
- `cpu_reset`  in  1  reset: one clock, synchronous, active-low (0 = reset).
- `write_strobe`  in  1  from `pico_top` `write_strobeS`.
- `read_strobe`  in  1  from `pico_top` `read_strobeS`.
- `port_id`  in  8  from `port_idS`.
- `out_port`  in  8  from `out_portS`.
- `ext_in`  in  8  pass-through data for IDs outside the window.
- `in_port`  out  8  registered read data to `pico_top`.
- `interrupt`  out  1  drain-complete request.
- `interrupt_ack`  in  1  from `pico_top`.
- `m_valid`  out  1  FIFO head valid.
- `m_ready`  in  1  consumer accepts head.
- `m_tag`  out  2  head entry `port_id[1:0]`.
- `m_data`  out  8  head entry data.

## Operation
- Window hit: `port_id[7:2] == BASE_ID[7:2]`.
- Push: `write_strobe && hit && !full` stores {`port_id[1:0]`, `out_port`}.
- Overflow: `write_strobe && hit && full && !pop` drops the write and sets sticky `ovf`.
- Pop: `m_valid && m_ready`. Head is show-ahead: `m_tag`/`m_data` come from the storage array at the read pointer.
- `m_valid = !empty`. `m_tag`/`m_data` are don't-care while empty.
- Pointers are `AW+1` bits and wrap modulo `2*DEPTH`.
  - `full` = MSBs differ and low bits are equal.
  - `empty` = pointers equal.
- Read mux, registered every cycle regardless of `read_strobe`:
  - `BASE+0`: {5'b0, `ovf`, `full`, `empty`}.
  - `BASE+1`: count, zero-extended to 8 bits.
  - `BASE+2`: {6'b0, head tag}.
  - `BASE+3`: head data.
  - Non-hit IDs: `ext_in`.
- Status clear: `read_strobe && port_id == BASE+0` clears `ovf`. A same-cycle overflow keeps `ovf` set (set wins).
- Interrupt:
  - Event: a pop with count == 1 and no push in the same cycle.
  - Event sets `interrupt`; `interrupt_ack` clears it.
  - If event and ack occur in the same cycle, set wins.
- Count update: +1 on push only, −1 on pop only, unchanged on both.

## Timing
- Reset (`cpu_reset` = 0 at an edge) clears pointers, count, `ovf`, `interrupt` and `in_port` to 0. `m_valid` = 0 after that edge.
- Reset mid-operation discards all entries, with no pop or interrupt generated.
- Write-to-`m_valid` latency: 1 cycle. The entry is visible the cycle after the `write_strobe` edge.
- `in_port` latency: 1 cycle after `port_id`/`ext_in`. This fits the PicoBlaze 2-cycle `INPUT` timing.
- Simultaneous push and pop:
  - When full: both occur, `ovf` is unchanged, count stays `DEPTH`.
  - When empty: no pop occurs (`m_valid` = 0), push occurs.
- Status reads reflect state as of the previous edge. An `ovf` clear is visible on the next read.
- `m_ready` may be held high continuously, giving 1 pop per cycle.

## Structure
- Package `pico_io_pkg`:
  - Offsets `OFS_STATUS` = 0, `OFS_COUNT` = 1, `OFS_TAG` = 2, `OFS_DATA` = 3.
  - Status bit indices `ST_EMPTY` = 0, `ST_FULL` = 1, `ST_OVF` = 2.
  - Entry width `ENTRY_W` = 10.
- Sub-module `pico_sync_fifo` (params `WIDTH`, `DEPTH`): storage, pointers, count, full/empty and show-ahead output.
- The top level holds the decode, overflow flag, interrupt logic and read mux.

## Test plan
- Reset then idle → `in_port` = 8'h01 at `port_id` 8'h10, `m_valid` = 0, `interrupt` = 0. `port_id` 8'h40 with `ext_in` 8'hF3 → `in_port` = 8'hF3 after 1 cycle.
- Write 8'hF3 to 8'h12 with `m_ready` = 0 → next cycle `m_valid` = 1, `m_tag` = 2, `m_data` = 8'hF3. Read 8'h11 → 8'h01.
- 17 writes (8'h00..8'h10) to 8'h10 with `m_ready` = 0 → status 8'h06 (ovf and full), count 8'h10, the 8'h10 write lost. Read 8'h10 with `read_strobe` → next status 8'h02.
- From full, `m_ready` = 1 for 16 cycles → data 8'h00..8'h0F in order, 1 per cycle. `interrupt` rises the cycle after the last pop and holds until an `interrupt_ack` pulse.
- Full FIFO, push and pop in the same cycle → count stays 16, `ovf` stays 0, pushed entry emerges 16th.
- `cpu_reset` low for 1 cycle with 5 entries and `interrupt` = 1 → next cycle `m_valid` = 0, status 8'h01, `interrupt` = 0.
